axi_write_arbiter: RTL and testbench

//  Write-path arbiter/scheduler for the AXI bridge. Per slave, picks one master, then holds the route until the B handshake.

---
 rtl/axi_arb_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/axi_write_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Purpose: shared slave indices, write-path address map and route-state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axi_arb_pkg;

    // Number of address-mapped slaves. DEFAULT sits just above them.
    localparam int MAP_SLAVES = 6;

    localparam logic [2:0] S_ROM     = 3'd0;
    localparam logic [2:0] S_IM      = 3'd1;
    localparam logic [2:0] S_DM      = 3'd2;
    localparam logic [2:0] S_WDT     = 3'd3;
    localparam logic [2:0] S_DMA     = 3'd4;
    localparam logic [2:0] S_DRAM    = 3'd5;
    localparam logic [2:0] S_DEFAULT = 3'd6;

    // Inclusive ranges. Entry i belongs to slave index i.
    localparam logic [MAP_SLAVES-1:0][31:0] MAP_BASE = {
        32'h2000_0000, 32'h1002_0000, 32'h1001_0000,
        32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [MAP_SLAVES-1:0][31:0] MAP_LIMIT = {
        32'h201F_FFFF, 32'h1002_03FF, 32'h1001_03FF,
        32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_3FFF
    };

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} warb_state_e;

    // Returns the slave owning addr; anything outside the map goes to DEFAULT.
    function automatic logic [2:0] addr_decode(input logic [31:0] addr);
        logic [2:0] idx;
        idx = S_DEFAULT;
        for (int i = 0; i < MAP_SLAVES; i++) begin
            if (addr >= MAP_BASE[i] && addr <= MAP_LIMIT[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: picks one requester out of N; round-robin, or fixed priority with WARB_FIXED_PRIO_EN.
// Latency: combinational grant; pointer updates on the clock edge after an accepted grant.
// Backpressure: pointer only moves when advance is high and a grant exists.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

`ifdef WARB_FIXED_PRIO_EN
    // Lowest requesting index wins; scan high to low so the last hit is the lowest.
    always_comb begin
        grant_idx = '0;
        any_grant = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any_grant && req[IW'(j)]) begin
                any_grant = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    // Pointer lands just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && any_grant) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/axi_write_arbiter.sv
// Purpose: per-slave write route scheduler driving SWIdx/MWIdx; WARB_FIXED_PRIO_EN selects fixed priority.
// Latency: 1 cycle from AWVALID_M to registered route select; route held until B handshake.
// Backpressure: waits on AW, W(last) and B handshakes; busy masters and non-idle slaves get no grant.
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M     = 3,
    parameter int NUM_S     = 6,
    parameter int MIDX_BITS = 3,
    parameter int SIDX_BITS = 2
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [NUM_M-1:0]                    AWVALID_M,
    input  logic [NUM_M-1:0][31:0]              AWADDR_M,
    input  logic [NUM_S:0]                      AWVALID_S,
    input  logic [NUM_S:0]                      AWREADY_S,
    input  logic [NUM_S:0]                      WVALID_S,
    input  logic [NUM_S:0]                      WREADY_S,
    input  logic [NUM_S:0]                      WLAST_S,
    input  logic [NUM_S:0]                      BVALID_S,
    input  logic [NUM_S:0]                      BREADY_S,
    output logic [NUM_S:0][SIDX_BITS-1:0]       SWIdx,
    output logic [NUM_M-1:0][MIDX_BITS-1:0]     MWIdx
);

    localparam int NS = NUM_S + 1;
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [SIDX_BITS-1:0] NO_M = SIDX_BITS'(NUM_M);
    localparam logic [MIDX_BITS-1:0] NO_S = MIDX_BITS'(NUM_S + 1);

    logic [NUM_M-1:0][MIDX_BITS-1:0] dec;
    logic [NUM_M-1:0]                busy;
    logic [NS-1:0][NUM_M-1:0]        req;
    logic [NS-1:0]                   advance;
    logic [NS-1:0][GW-1:0]           gnt_idx;
    logic [NS-1:0]                   gnt_any;

    warb_state_e                     state_q [NS];
    warb_state_e                     state_d [NS];
    logic [NS-1:0][SIDX_BITS-1:0]    swidx_d;
    logic [NUM_M-1:0][MIDX_BITS-1:0] mwidx_d;

    // Decode each master's target; a master holding a route is busy everywhere.
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            dec[m]  = MIDX_BITS'(addr_decode(AWADDR_M[m]));
            busy[m] = (MWIdx[m] != NO_S);
        end
    end

    // Requests per slave: only idle slaves see requests, only free masters make them.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            advance[s] = (state_q[s] == IDLE);
            for (int m = 0; m < NUM_M; m++) begin
                req[s][m] = AWVALID_M[m] && (dec[m] == MIDX_BITS'(s)) && !busy[m]
                            && (state_q[s] == IDLE);
            end
        end
    end

    for (genvar gs = 0; gs < NS; gs++) begin : g_arb
        rr_arbiter #(.N(NUM_M)) u_arb (
            .clk       (ACLK),
            .rst_n     (ARESETn),
            .req       (req[gs]),
            .advance   (advance[gs]),
            .grant_idx (gnt_idx[gs]),
            .any_grant (gnt_any[gs])
        );
    end

    // Route FSM per slave: grant, then follow AW, W-last and B handshakes back to idle.
    always_comb begin
        swidx_d = SWIdx;
        mwidx_d = MWIdx;
        for (int s = 0; s < NS; s++) begin
            state_d[s] = state_q[s];
            case (state_q[s])
                IDLE: begin
                    if (gnt_any[s]) begin
                        state_d[s]          = ADDR;
                        swidx_d[s]          = SIDX_BITS'(gnt_idx[s]);
                        mwidx_d[gnt_idx[s]] = MIDX_BITS'(s);
                    end
                end
                ADDR: begin
                    if (AWVALID_S[s] && AWREADY_S[s]) state_d[s] = DATA;
                end
                DATA: begin
                    if (WVALID_S[s] && WREADY_S[s] && WLAST_S[s]) state_d[s] = RESP;
                end
                RESP: begin
                    if (BVALID_S[s] && BREADY_S[s]) begin
                        state_d[s]                 = IDLE;
                        swidx_d[s]                 = NO_M;
                        mwidx_d[SWIdx[s][GW-1:0]]  = NO_S;
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    // Register states and route selects; reset drops every route immediately.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int s = 0; s < NS; s++) begin
                state_q[s] <= IDLE;
                SWIdx[s]   <= NO_M;
            end
            for (int m = 0; m < NUM_M; m++) begin
                MWIdx[m] <= NO_S;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                state_q[s] <= state_d[s];
            end
            SWIdx <= swidx_d;
            MWIdx <= mwidx_d;
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
module tb_axi_write_arbiter;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [2:0]       AWVALID_M;
    logic [2:0][31:0] AWADDR_M;
    logic [6:0]       AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, WLAST_S, BVALID_S, BREADY_S;
    logic [6:0][1:0]  SWIdx;
    logic [2:0][2:0]  MWIdx;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_m;

    always #5 ACLK = ~ACLK;

    axi_write_arbiter dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWVALID_M (AWVALID_M),
        .AWADDR_M  (AWADDR_M),
        .AWVALID_S (AWVALID_S),
        .AWREADY_S (AWREADY_S),
        .WVALID_S  (WVALID_S),
        .WREADY_S  (WREADY_S),
        .WLAST_S   (WLAST_S),
        .BVALID_S  (BVALID_S),
        .BREADY_S  (BREADY_S),
        .SWIdx     (SWIdx),
        .MWIdx     (MWIdx)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic route(input string tag, input int s, input int m);
        check({tag, "_swidx"}, 8'(SWIdx[s]), 8'(m));
        check({tag, "_mwidx"}, 8'(MWIdx[m]), 8'(s));
    endtask

    task automatic freed(input string tag, input int s, input int m);
        check({tag, "_swidx"}, 8'(SWIdx[s]), 8'd3);
        check({tag, "_mwidx"}, 8'(MWIdx[m]), 8'd7);
    endtask

    task automatic aw_hs(input int s);
        AWVALID_S[s] = 1'b1; AWREADY_S[s] = 1'b1;
        tick();
        AWVALID_S[s] = 1'b0; AWREADY_S[s] = 1'b0;
    endtask

    task automatic w_beats(input int s, input int n, input bit end_burst);
        for (int i = 0; i < n; i++) begin
            WVALID_S[s] = 1'b1; WREADY_S[s] = 1'b1;
            WLAST_S[s]  = end_burst && (i == n - 1);
            tick();
        end
        WVALID_S[s] = 1'b0; WREADY_S[s] = 1'b0; WLAST_S[s] = 1'b0;
    endtask

    task automatic b_hs(input int s);
        BVALID_S[s] = 1'b1; BREADY_S[s] = 1'b1;
        tick();
        BVALID_S[s] = 1'b0; BREADY_S[s] = 1'b0;
    endtask

    task automatic finish_write(input int s);
        aw_hs(s);
        w_beats(s, 1, 1'b1);
        b_hs(s);
    endtask

    initial begin
        ARESETn   = 1'b0;
        AWVALID_M = '0;
        AWADDR_M  = '0;
        AWVALID_S = '0; AWREADY_S = '0;
        WVALID_S  = '0; WREADY_S  = '0; WLAST_S = '0;
        BVALID_S  = '0; BREADY_S  = '0;

        // Reset values
        tick();
        tick();
        for (int s = 0; s < 7; s++) check("reset_swidx", 8'(SWIdx[s]), 8'd3);
        for (int m = 0; m < 3; m++) check("reset_mwidx", 8'(MWIdx[m]), 8'd7);
        ARESETn = 1'b1;
        tick();

        // Single write M1 -> DM, 4 beats
        AWADDR_M[1]  = 32'h0002_0010;
        AWVALID_M[1] = 1'b1;
        check("t2_pre_grant", 8'(SWIdx[2]), 8'd3);
        tick();
        route("t2_grant", 2, 1);
        AWVALID_M[1] = 1'b0;
        tick();
        tick();
        route("t2_hold_addr", 2, 1);
        aw_hs(2);
        w_beats(2, 3, 1'b0);
        route("t2_mid_burst", 2, 1);
        w_beats(2, 1, 1'b1);
        route("t2_wait_b", 2, 1);
        b_hs(2);
        freed("t2_release", 2, 1);

        // Contention on DRAM, round one: 0,1,2
        AWADDR_M  = {32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
        AWVALID_M = 3'b111;
        tick();
        route("t3_g0", 5, 0);
        check("t3_m1_unrouted", 8'(MWIdx[1]), 8'd7);
        AWVALID_M[0] = 1'b0;
        finish_write(5);
        check("t3_idle_gap", 8'(SWIdx[5]), 8'd3);
        tick();
        route("t3_g1", 5, 1);
        AWVALID_M[1] = 1'b0;
        finish_write(5);
        tick();
        route("t3_g2", 5, 2);
        AWVALID_M[2] = 1'b0;
        finish_write(5);
        freed("t3_done", 5, 2);

        // Contention round two, M0 keeps requesting
        AWVALID_M = 3'b111;
        tick();
        route("t3_r2_g0", 5, 0);
        finish_write(5);
        tick();
`ifdef WARB_FIXED_PRIO_EN
        exp_m = 0;
`else
        exp_m = 1;
`endif
        route("t3_r2_g1", 5, exp_m);
        AWVALID_M = 3'b000;
        finish_write(5);
        freed("t3_r2_done", 5, exp_m);

        // Concurrent routes M0 -> IM, M1 -> WDT
        AWADDR_M[0] = 32'h0001_0000;
        AWADDR_M[1] = 32'h1001_0000;
        AWVALID_M   = 3'b011;
        tick();
        route("t4_im", 1, 0);
        route("t4_wdt", 3, 1);
        AWVALID_M = 3'b000;
        aw_hs(1);
        aw_hs(3);
        w_beats(3, 2, 1'b1);
        b_hs(3);
        freed("t4_wdt_done", 3, 1);
        route("t4_im_alive", 1, 0);
        w_beats(1, 1, 1'b1);
        b_hs(1);
        freed("t4_im_done", 1, 0);

        // Unmapped address goes to DEFAULT
        AWADDR_M[2]  = 32'h3000_0000;
        AWVALID_M[2] = 1'b1;
        tick();
        route("t5_default", 6, 2);
        AWVALID_M = 3'b000;
        finish_write(6);
        freed("t5_default_done", 6, 2);

        // ROM upper edge and one past it
        AWADDR_M[0] = 32'h0000_3FFF;
        AWADDR_M[1] = 32'h0000_4000;
        AWVALID_M   = 3'b011;
        tick();
        route("t5_rom_edge", 0, 0);
        route("t5_rom_past", 6, 1);
        AWVALID_M = 3'b000;
        finish_write(0);
        finish_write(6);
        freed("t5_rom_done", 0, 0);
        freed("t5_past_done", 6, 1);

        // Reset during W beat 2
        AWADDR_M[0]  = 32'h2000_0000;
        AWVALID_M[0] = 1'b1;
        tick();
        route("t6_grant", 5, 0);
        AWVALID_M = 3'b000;
        aw_hs(5);
        w_beats(5, 1, 1'b0);
        WVALID_S[5] = 1'b1; WREADY_S[5] = 1'b1;
        #2;
        ARESETn = 1'b0;
        #1;
        freed("t6_async_reset", 5, 0);
        WVALID_S[5] = 1'b0; WREADY_S[5] = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        AWADDR_M[0]  = 32'h0002_0000;
        AWVALID_M[0] = 1'b1;
        tick();
        route("t6_fresh_grant", 2, 0);
        AWVALID_M = 3'b000;
        finish_write(2);
        freed("t6_fresh_done", 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
